// File: rtl/nested_vic_pkg.sv
// Shared constants for the nested vectored interrupt controller.
// Holds the interrupt count, data/address widths and the register map.
package nested_vic_pkg;

  localparam int NUM_IRQ = 16;
  localparam int DATA_W  = 16;
  localparam int IDX_W   = 4;
  localparam int ADDR_W  = 5;

  localparam logic [ADDR_W-1:0] ADDR_ENABLE    = 5'd0;
  localparam logic [ADDR_W-1:0] ADDR_PENDING   = 5'd1;
  localparam logic [ADDR_W-1:0] ADDR_INSERVICE = 5'd2;
  localparam logic [ADDR_W-1:0] ADDR_RAW       = 5'd3;
  localparam logic [ADDR_W-1:0] ADDR_CURVEC    = 5'd6;
  localparam logic [ADDR_W-1:0] ADDR_EOI       = 5'd7;
  localparam logic [ADDR_W-1:0] VEC_BASE       = 5'd16;

endpackage

// File: rtl/nested_vic_prio_enc.sv
// Lowest-index-first priority encoder.
// Ports:
//   req   - request vector, bit 0 is highest priority
//   valid - at least one request bit set
//   idx   - index of the highest-priority set bit (0 when none)
module nested_vic_prio_enc
  import nested_vic_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/nested_vic.sv
// Nested vectored interrupt controller with a small register-mapped interface.
// Rising edges on the interrupt lines latch into PENDING; the highest-priority
// enabled pending line is presented to the processor only when it outranks
// everything currently in service.
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-low reset
//   cs             - chip select for all register accesses
//   datain/port_id - write data and register address
//   read_strobe    - read qualifier (reads have no side effects)
//   write_strobe   - one-cycle write qualifier
//   dout           - registered read data, reloaded on every cs cycle
//   interrupts     - interrupt request lines, bit 0 highest priority
//   IntAck         - one-cycle acknowledge from the processor
//   InterruptOut   - registered interrupt request to the processor
module nested_vic
  import nested_vic_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cs,
  input  logic [DATA_W-1:0]  datain,
  input  logic [ADDR_W-1:0]  port_id,
  input  logic               read_strobe,
  input  logic               write_strobe,
  output logic [DATA_W-1:0]  dout,
  input  logic [NUM_IRQ-1:0] interrupts,
  input  logic               IntAck,
  output logic               InterruptOut
);

  logic [NUM_IRQ-1:0] enable;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] inservice;
  logic [NUM_IRQ-1:0] prev_irq;
  logic [IDX_W-1:0]   cur_id;
  logic [DATA_W-1:0]  cur_vec;
  logic [DATA_W-1:0]  vec [NUM_IRQ];

  logic               wr;
  logic               wr_eoi;
  logic               ack;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] w1c_mask;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [NUM_IRQ-1:0] eoi_mask;
  logic               pend_vld;
  logic [IDX_W-1:0]   pend_idx;
  logic               isr_vld;
  logic [IDX_W-1:0]   isr_idx;
  logic               req;
  logic [DATA_W-1:0]  rd_data;
  logic               unused_rd;

  // Reads are side-effect free and dout follows cs alone, so the read
  // qualifier carries no information for this block.
  assign unused_rd = read_strobe;

  assign wr       = cs & write_strobe;
  assign wr_eoi   = wr & (port_id == ADDR_EOI);
  assign ack      = IntAck & InterruptOut;
  assign rise     = interrupts & ~prev_irq;
  assign w1c_mask = (wr && port_id == ADDR_PENDING) ? datain : '0;

  nested_vic_prio_enc u_pend_enc (
    .req   (pending & enable),
    .valid (pend_vld),
    .idx   (pend_idx)
  );

  nested_vic_prio_enc u_isr_enc (
    .req   (inservice),
    .valid (isr_vld),
    .idx   (isr_idx)
  );

  // A request must strictly outrank the most important line in service.
  assign req = pend_vld && (!isr_vld || (pend_idx < isr_idx));

  always_comb begin
    ack_mask          = '0;
    eoi_mask          = '0;
    ack_mask[cur_id]  = ack;
    eoi_mask[isr_idx] = wr_eoi & isr_vld;
  end

  always_comb begin
    rd_data = '0;
    if (port_id[ADDR_W-1]) begin
      rd_data = vec[port_id[IDX_W-1:0]];
    end else begin
      case (port_id)
        ADDR_ENABLE:    rd_data = enable;
        ADDR_PENDING:   rd_data = pending;
        ADDR_INSERVICE: rd_data = inservice;
        ADDR_RAW:       rd_data = interrupts;
        ADDR_CURVEC:    rd_data = cur_vec;
        default:        rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable       <= '0;
      pending      <= '0;
      inservice    <= '0;
      prev_irq     <= '0;
      cur_id       <= '0;
      cur_vec      <= '0;
      dout         <= '0;
      InterruptOut <= 1'b0;
      for (int i = 0; i < NUM_IRQ; i++) begin
        vec[i] <= '0;
      end
    end else begin
      prev_irq <= interrupts;
      // A fresh edge overrides a same-cycle clear from ack or W1C.
      pending   <= (pending & ~(w1c_mask | ack_mask)) | rise;
      inservice <= (inservice | ack_mask) & ~eoi_mask;

      if (wr && port_id == ADDR_ENABLE) begin
        enable <= datain;
      end
      if (wr && port_id[ADDR_W-1]) begin
        vec[port_id[IDX_W-1:0]] <= datain;
      end
      if (cs) begin
        dout <= rd_data;
      end

      // The presented id/vector stay frozen until acknowledged; the ack edge
      // itself does not re-arbitrate.
      if (InterruptOut) begin
        if (IntAck) begin
          InterruptOut <= 1'b0;
        end
      end else if (req) begin
        InterruptOut <= 1'b1;
        cur_id       <= pend_idx;
        cur_vec      <= vec[pend_idx];
      end
    end
  end

endmodule

// File: tb/tb_nested_vic.sv
module tb_nested_vic;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic [15:0] datain = '0;
  logic [4:0]  port_id = '0;
  logic        read_strobe = 1'b0;
  logic        write_strobe = 1'b0;
  logic [15:0] dout;
  logic [15:0] interrupts = '0;
  logic        IntAck = 1'b0;
  logic        InterruptOut;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_en, m_pend, m_ins, m_prev, m_curvec, m_dout;
  logic [15:0] m_vec [16];
  int          m_curid;
  bit          m_int;

  always #5 clk = ~clk;

  nested_vic dut (
    .clk          (clk),
    .rst          (rst),
    .cs           (cs),
    .datain       (datain),
    .port_id      (port_id),
    .read_strobe  (read_strobe),
    .write_strobe (write_strobe),
    .dout         (dout),
    .interrupts   (interrupts),
    .IntAck       (IntAck),
    .InterruptOut (InterruptOut)
  );

  function automatic int first_set(logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return 16;
  endfunction

  function automatic logic [15:0] m_read(logic [4:0] a);
    int ai;
    ai = int'(a);
    if (ai >= 16) return m_vec[ai - 16];
    case (ai)
      0: return m_en;
      1: return m_pend;
      2: return m_ins;
      3: return interrupts;
      6: return m_curvec;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic model_zero();
    m_en = '0; m_pend = '0; m_ins = '0; m_prev = '0;
    m_curvec = '0; m_dout = '0; m_curid = 0; m_int = 0;
    for (int i = 0; i < 16; i++) m_vec[i] = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [15:0] rise, clr, n_pend, n_ins, n_en, n_dout;
    int p, s;
    bit wr, ack;
    wr     = cs && write_strobe;
    ack    = IntAck && m_int;
    rise   = interrupts & ~m_prev;
    p      = first_set(m_pend & m_en);
    s      = first_set(m_ins);
    n_dout = cs ? m_read(port_id) : m_dout;
    clr    = '0;
    if (wr && port_id == 5'd1) clr = datain;
    n_ins = m_ins;
    if (ack) begin
      clr[m_curid]   = 1'b1;
      n_ins[m_curid] = 1'b1;
    end
    if (wr && port_id == 5'd7 && s < 16) n_ins[s] = 1'b0;
    n_pend = (m_pend & ~clr) | rise;
    n_en   = (wr && port_id == 5'd0) ? datain : m_en;
    if (m_int) begin
      if (ack) m_int = 0;
    end else if (p < 16 && p < s) begin
      m_int    = 1;
      m_curid  = p;
      m_curvec = m_vec[p];
    end
    if (wr && int'(port_id) >= 16) m_vec[int'(port_id) - 16] = datain;
    m_pend = n_pend;
    m_ins  = n_ins;
    m_en   = n_en;
    m_dout = n_dout;
    m_prev = interrupts;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
    cs = 1'b1; write_strobe = 1'b1; port_id = a; datain = d;
    cycle();
    cs = 1'b0; write_strobe = 1'b0;
  endtask

  task automatic rd_reg(input logic [4:0] a);
    cs = 1'b1; read_strobe = 1'b1; port_id = a;
    cycle();
    cs = 1'b0; read_strobe = 1'b0;
  endtask

  task automatic do_reset();
    cs = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0; IntAck = 1'b0;
    interrupts = '0; datain = '0; port_id = '0;
    rst = 1'b0;
    model_zero();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic load_vectors();
    for (int i = 0; i < 16; i++) wr_reg(5'(16 + i), 16'(100 + i));
  endtask

  task automatic test_reset();
    cs = 1'b1; port_id = 5'd16;
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0000 || InterruptOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs dout=%h irq=%b exp dout=0000 irq=0", dout, InterruptOut);
    end
    do_reset();
    for (int a = 0; a < 32; a += 3) begin
      rd_reg(5'(a));
      checks++;
      if (dout !== 16'h0000) begin
        errors++;
        $display("FAIL reset_reg%0d got=%h exp=0000", a, dout);
      end
    end
  endtask

  task automatic test_vectors();
    do_reset();
    load_vectors();
    for (int i = 0; i < 16; i++) begin
      rd_reg(5'(16 + i));
      checks++;
      if (dout !== 16'(100 + i)) begin
        errors++;
        $display("FAIL vector%0d got=%0d exp=%0d", i, dout, 100 + i);
      end
    end
    wr_reg(5'd5, 16'hBEEF);
    rd_reg(5'd5);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL unmapped_port got=%h exp=0000", dout);
    end
  endtask

  task automatic test_first_irq();
    wr_reg(5'd0, 16'hFFFF);
    interrupts = 16'hFFFF;
    cycle();
    checks++;
    if (InterruptOut !== 1'b0) begin
      errors++;
      $display("FAIL irq_edge1 got=%b exp=0", InterruptOut);
    end
    interrupts = 16'hFFFF;
    cycle();
    checks++;
    if (InterruptOut !== 1'b1) begin
      errors++;
      $display("FAIL irq_edge2 got=%b exp=1", InterruptOut);
    end
    rd_reg(5'd6);
    checks++;
    if (dout !== 16'd100) begin
      errors++;
      $display("FAIL curvec_first got=%0d exp=100", dout);
    end
  endtask

  task automatic test_ack_eoi();
    IntAck = 1'b1;
    cycle();
    IntAck = 1'b0;
    checks++;
    if (InterruptOut !== 1'b0) begin
      errors++;
      $display("FAIL ack_drop got=%b exp=0", InterruptOut);
    end
    rd_reg(5'd2);
    checks++;
    if (dout !== 16'h0001) begin
      errors++;
      $display("FAIL inservice_after_ack got=%h exp=0001", dout);
    end
    rd_reg(5'd1);
    checks++;
    if (dout !== 16'hFFFE) begin
      errors++;
      $display("FAIL pending_after_ack got=%h exp=fffe", dout);
    end
    // A stray ack while idle must change nothing.
    IntAck = 1'b1;
    cycle();
    IntAck = 1'b0;
    cycle();
    checks++;
    if (InterruptOut !== 1'b0) begin
      errors++;
      $display("FAIL blocked_by_isr got=%b exp=0", InterruptOut);
    end
    wr_reg(5'd7, 16'h1234);
    cycle();
    checks++;
    if (InterruptOut !== 1'b1) begin
      errors++;
      $display("FAIL after_eoi got=%b exp=1", InterruptOut);
    end
    rd_reg(5'd6);
    checks++;
    if (dout !== 16'd101) begin
      errors++;
      $display("FAIL curvec_after_eoi got=%0d exp=101", dout);
    end
  endtask

  task automatic test_nesting();
    do_reset();
    load_vectors();
    wr_reg(5'd0, 16'h0020);
    interrupts = 16'h0020;
    cycle();
    cycle();
    IntAck = 1'b1;
    cycle();
    IntAck = 1'b0;
    wr_reg(5'd0, 16'hFFFF);
    interrupts = 16'h0024;
    cycle();
    cycle();
    checks++;
    if (InterruptOut !== 1'b1) begin
      errors++;
      $display("FAIL nest_preempt got=%b exp=1", InterruptOut);
    end
    rd_reg(5'd6);
    checks++;
    if (dout !== 16'd102) begin
      errors++;
      $display("FAIL nest_curvec got=%0d exp=102", dout);
    end
    IntAck = 1'b1;
    cycle();
    IntAck = 1'b0;
    wr_reg(5'd7, 16'h0000);
    rd_reg(5'd2);
    checks++;
    if (dout !== 16'h0020) begin
      errors++;
      $display("FAIL nest_eoi_isr got=%h exp=0020", dout);
    end
    interrupts = 16'h0224;
    for (int i = 0; i < 4; i++) begin
      cycle();
      checks++;
      if (InterruptOut !== 1'b0) begin
        errors++;
        $display("FAIL nest_lowprio_cyc%0d got=%b exp=0", i, InterruptOut);
      end
    end
    rd_reg(5'd1);
    checks++;
    if (dout !== 16'h0200) begin
      errors++;
      $display("FAIL nest_pending got=%h exp=0200", dout);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    interrupts = 16'h0008;
    cycle();
    interrupts = 16'h0000;
    cycle();
    interrupts = 16'h0008;
    wr_reg(5'd1, 16'h0008);
    rd_reg(5'd1);
    checks++;
    if (dout !== 16'h0008) begin
      errors++;
      $display("FAIL set_wins got=%h exp=0008", dout);
    end
    wr_reg(5'd1, 16'h0008);
    rd_reg(5'd1);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL w1c_clear got=%h exp=0000", dout);
    end
  endtask

  task automatic test_mask();
    do_reset();
    load_vectors();
    interrupts = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (InterruptOut !== 1'b0) begin
        errors++;
        $display("FAIL masked_cyc%0d got=%b exp=0", i, InterruptOut);
      end
    end
    rd_reg(5'd1);
    checks++;
    if (dout !== 16'hFFFF) begin
      errors++;
      $display("FAIL masked_pending got=%h exp=ffff", dout);
    end
    wr_reg(5'd0, 16'h0001);
    cycle();
    checks++;
    if (InterruptOut !== 1'b1) begin
      errors++;
      $display("FAIL unmask_req got=%b exp=1", InterruptOut);
    end
    rd_reg(5'd6);
    checks++;
    if (dout !== 16'd100) begin
      errors++;
      $display("FAIL unmask_curvec got=%0d exp=100", dout);
    end
  endtask

  task automatic test_reset_mid();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== 16'h0000 || InterruptOut !== 1'b0) begin
      errors++;
      $display("FAIL async_reset dout=%h irq=%b exp dout=0000 irq=0", dout, InterruptOut);
    end
    model_zero();
    @(posedge clk);
    #1;
    rst = 1'b1;
    interrupts = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (InterruptOut !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_cyc%0d got=%b exp=0", i, InterruptOut);
      end
    end
    rd_reg(5'd16);
    checks++;
    if (dout !== 16'h0000) begin
      errors++;
      $display("FAIL post_reset_vec got=%h exp=0000", dout);
    end
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      interrupts   = interrupts ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      cs           = ($urandom_range(0, 9) < 7);
      write_strobe = ($urandom_range(0, 9) < 2);
      read_strobe  = ~write_strobe;
      IntAck       = ($urandom_range(0, 4) == 0);
      datain       = 16'($urandom);
      r = $urandom_range(0, 9);
      case (r)
        0, 1: port_id = 5'd0;
        2:    port_id = 5'd1;
        3:    port_id = 5'd7;
        4:    port_id = 5'd2;
        5:    port_id = 5'd6;
        6, 7: port_id = 5'(16 + $urandom_range(0, 15));
        default: port_id = 5'($urandom_range(0, 31));
      endcase
      cycle();
      checks++;
      if (InterruptOut !== 1'(m_int) || dout !== m_dout) begin
        errors++;
        $display("FAIL random_cyc%0d irq=%b dout=%h exp irq=%b dout=%h",
                 n, InterruptOut, dout, m_int, m_dout);
      end
    end
    cs = 1'b0; write_strobe = 1'b0; read_strobe = 1'b0; IntAck = 1'b0;
  endtask

  initial begin
    model_zero();
    test_reset();
    test_vectors();
    test_first_irq();
    test_ack_eoi();
    test_nesting();
    test_set_wins();
    test_mask();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nested_vic.md
NESTED_VIC -- requirements
Module: nested_vic

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: ports clk (in, 1, rising-edge clock) and rst (in, 1, asynchronous active-low reset).
REQ-002 SHALL have port cs (in, 1): chip select; qualifies all register accesses.
REQ-003 SHALL have port datain (in, 16): write data.
REQ-004 SHALL have port port_id (in, 5): register address.
REQ-005 SHALL have port read_strobe (in, 1): read qualifier; reads have no side effects.
REQ-006 SHALL have port write_strobe (in, 1): write qualifier, one cycle.
REQ-007 SHALL have port dout (out, 16): registered read data.
REQ-008 SHALL have port interrupts (in, 16): interrupt request lines; bit 0 is highest priority.
REQ-009 SHALL have port IntAck (in, 1): one-cycle acknowledge pulse from the processor.
REQ-010 SHALL have port InterruptOut (out, 1): registered interrupt request to the processor.

Function
REQ-011 Register map SHALL be: 0 ENABLE (RW); 1 PENDING (R, write-1-to-clear); 2 INSERVICE (R); 3 raw interrupts (R); 6 CURVEC (R); 7 EOI (W, data ignored); 16..31 VECTOR[0..15] (RW, 16 bit); all other addresses read 0 and ignore writes.
REQ-012 Write SHALL occur on a rising edge with cs=1 and write_strobe=1, storing datain into register[port_id].
REQ-013 On every rising edge with cs=1, dout SHALL load the register selected by port_id; with cs=0, dout SHALL hold.
REQ-014 Interrupt lines SHALL be edge-detected: prev <= interrupts each cycle; rise = interrupts & ~prev ORs into PENDING.
REQ-015 Request condition: req = highest-priority bit of (PENDING & ENABLE) exists and has strictly higher priority than the highest set INSERVICE bit (or INSERVICE = 0).
REQ-016 When InterruptOut=0 and req holds, on the next edge InterruptOut SHALL go 1, and the winning index and VECTOR[index] SHALL latch into CURID/CURVEC.
REQ-017 While InterruptOut=1, CURID/CURVEC SHALL stay frozen; later or higher-priority arrivals only set PENDING.
REQ-018 On an edge with IntAck=1 and InterruptOut=1: INSERVICE[CURID] set, PENDING[CURID] cleared, InterruptOut cleared; arbitration resumes on the following edge.
REQ-019 IntAck while InterruptOut=0 SHALL be ignored.
REQ-020 A write to EOI SHALL clear the highest-priority set INSERVICE bit; no effect if INSERVICE = 0.
REQ-021 A new rising edge on a bit in the same cycle as its clear (ack or W1C) SHALL leave PENDING set (set wins).
REQ-022 Clearing an ENABLE bit SHALL mask its request but SHALL NOT clear PENDING.
REQ-023 Latency: interrupt rise before edge t0 -> PENDING at t0 -> InterruptOut at t0+1.

Reset
REQ-024 With rst=0, asynchronously: ENABLE, PENDING, INSERVICE, prev, CURID, CURVEC, all VECTOR registers, dout = 0, and InterruptOut = 0.
REQ-025 Reset asserted mid-request or mid-service SHALL abandon all state; after release, no request is issued until a new interrupt edge occurs.

Structure
REQ-026 A shared package SHALL hold NUM_IRQ=16, the data width (16), and the port-address constants (0, 1, 2, 3, 6, 7, and VEC_BASE=16).
REQ-027 Sub-module nested_vic_prio_enc SHALL implement a 16-bit lowest-index-first priority encoder (valid + 4-bit index), instanced for pending and for in-service.

Verification
REQ-028 Write 100+i to port 16+i for i=0..15, then read back -> dout = 100..115 (decimal), i.e. 0x64..0x73.
REQ-029 ENABLE=0xFFFF, interrupts 0->0xFFFF -> InterruptOut rises 2 edges later; read port 6 -> 100 (0x64).
REQ-030 IntAck pulse -> INSERVICE=0x0001, PENDING=0xFFFE, InterruptOut=0 and stays 0; EOI write -> InterruptOut=1, CURVEC=101.
REQ-031 Nesting: INSERVICE bit 5 set; raise interrupts[2] -> InterruptOut=1, CURVEC=102; raise interrupts[9] -> no request.
REQ-032 ENABLE=0x0000 with interrupts rising -> PENDING=0xFFFF, InterruptOut stays 0; then ENABLE=0x0001 -> request with vector 100.
REQ-033 rst=0 while InterruptOut=1 -> all outputs 0 immediately; after release, holding interrupts high produces no request.
